// File: rtl/ee357_seq_mult.sv
// Sequential shift-add multiplier: one iteration per clock, sign fix-up on the final edge.
// Operands are reduced to magnitudes at start; the product is negated in FIX when signs differ.
module ee357_seq_mult #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [PW-1:0]    prod, prod_nxt;
  logic             neg, neg_nxt;
  logic             busy_nxt, done_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;

  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    res_c;

  // Magnitudes of the incoming operands; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits.
  assign mag_a_c = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign mag_b_c = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // Upper partial product plus multiplicand, keeping the carry for the right shift.
  assign sum_c = {1'b0, prod[PW-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});
  assign res_c = neg ? (~prod + PW'(1)) : prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    mcand_nxt = mcand;
    prod_nxt  = prod;
    neg_nxt   = neg;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      S_IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          mcand_nxt = mag_a_c;
          prod_nxt  = {{WIDTH{1'b0}}, mag_b_c};
          neg_nxt   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          count_nxt = '0;
          busy_nxt  = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        prod_nxt  = {sum_c, prod[WIDTH-1:1]};
        count_nxt = count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        hi_nxt    = res_c[PW-1:WIDTH];
        lo_nxt    = res_c[WIDTH-1:0];
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        count_nxt = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        count_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs; hi/lo only move on the FIX edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      mcand <= '0;
      prod  <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      count <= count_nxt;
      mcand <= mcand_nxt;
      prod  <= prod_nxt;
      neg   <= neg_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

endmodule
